// File: rtl/mem_stage.sv
// MEM stage with the MEM/WB pipeline register: data-memory handshake, stall/bubble and timeout abort.
// Optional byte loads/stores are compiled in with `define MEM_BYTE_ACCESS_EN.
module mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ex_mem_valid,
    input  logic [31:0] ex_mem_alu_result,
    input  logic        ex_mem_alu_zero,
    input  logic        ex_mem_write_register,
    input  logic [4:0]  ex_mem_register_number,
    input  logic [1:0]  ex_mem_register_source,
    input  logic [31:0] ex_mem_pc4,
    input  logic [31:0] ex_mem_store_data,
    input  logic        ex_mem_mem_read,
    input  logic        ex_mem_mem_write,
    input  logic        ex_mem_byte,
    input  logic        ex_mem_unsigned,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        mem_fault,
    output logic [31:0] mem_wb_alu_result,
    output logic        mem_wb_alu_zero,
    output logic        mem_wb_write_register,
    output logic [4:0]  mem_wb_register_number,
    output logic [1:0]  mem_wb_register_source,
    output logic [31:0] mem_wb_pc4,
    output logic [31:0] mem_wb_data
);

    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ABORT = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  wait_cnt, wait_cnt_nxt;

    logic        access;
    logic        is_load;
    logic        in_abort;
    logic [31:0] load_val;

    // Counter never wraps, even if the limit were ever raised past its range.
    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    function automatic logic [31:0] load_lane(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input logic        zext);
        logic signed [7:0] lane;
        lane = word[8*off +: 8];
        return zext ? {24'h0, lane} : {{24{lane[7]}}, lane};
    endfunction

    assign access   = ex_mem_valid & (ex_mem_mem_read | ex_mem_mem_write);
    assign is_load  = ex_mem_valid & ex_mem_mem_read & ~ex_mem_mem_write;
    assign in_abort = (state == ST_ABORT);

    // Gated by reset so the request and stall fall the moment reset rises.
    assign dmem_req  = access & ~in_abort & ~reset;
    assign dmem_we   = dmem_req & ex_mem_mem_write;
    assign mem_stall = access & ~dmem_ready & ~in_abort & ~reset;
    assign dmem_addr = {ex_mem_alu_result[31:2], 2'b00};

`ifdef MEM_BYTE_ACCESS_EN
    always_comb begin
        dmem_be    = 4'hF;
        dmem_wdata = ex_mem_store_data;
        load_val   = dmem_rdata;
        if (ex_mem_byte) begin
            dmem_be    = 4'b0001 << ex_mem_alu_result[1:0];
            dmem_wdata = {4{ex_mem_store_data[7:0]}};
            load_val   = load_lane(dmem_rdata, ex_mem_alu_result[1:0], ex_mem_unsigned);
        end
    end
`else
    logic unused_byte_ctl;
    assign unused_byte_ctl = ex_mem_byte ^ ex_mem_unsigned;
    assign dmem_be    = 4'hF;
    assign dmem_wdata = ex_mem_store_data;
    assign load_val   = dmem_rdata;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            wait_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            ST_IDLE: begin
                if (access && !dmem_ready) begin
                    state_nxt    = ST_WAIT;
                    wait_cnt_nxt = 8'd1;
                end
            end
            ST_WAIT: begin
                if (!access || dmem_ready) begin
                    state_nxt    = ST_IDLE;
                    wait_cnt_nxt = 8'd0;
                end else if (wait_cnt >= TIMEOUT_LIM) begin
                    state_nxt    = ST_ABORT;
                end else begin
                    wait_cnt_nxt = sat_inc(wait_cnt);
                end
            end
            ST_ABORT: begin
                state_nxt    = ST_IDLE;
                wait_cnt_nxt = 8'd0;
            end
            default: begin
                state_nxt    = ST_IDLE;
                wait_cnt_nxt = 8'd0;
            end
        endcase
    end

    // MEM/WB register: bubble while stalled, fault completion suppresses the write-back
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_wb_alu_result      <= 32'd0;
            mem_wb_alu_zero        <= 1'b0;
            mem_wb_write_register  <= 1'b0;
            mem_wb_register_number <= 5'd0;
            mem_wb_register_source <= 2'd0;
            mem_wb_pc4             <= 32'd0;
            mem_wb_data            <= 32'd0;
            mem_fault              <= 1'b0;
        end else if (mem_stall) begin
            mem_wb_write_register  <= 1'b0;
            mem_fault              <= 1'b0;
        end else begin
            mem_wb_alu_result      <= ex_mem_alu_result;
            mem_wb_alu_zero        <= ex_mem_alu_zero;
            mem_wb_write_register  <= ex_mem_write_register & ex_mem_valid & ~in_abort;
            mem_wb_register_number <= ex_mem_register_number;
            mem_wb_register_source <= ex_mem_register_source;
            mem_wb_pc4             <= ex_mem_pc4;
            mem_wb_data            <= (is_load && !in_abort) ? load_val : 32'd0;
            mem_fault              <= in_abort;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage against a transaction-level model of latency, timeout and MEM/WB contents.
module tb_mem_stage;

    localparam int T = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        ex_mem_valid, ex_mem_alu_zero, ex_mem_write_register;
    logic [31:0] ex_mem_alu_result, ex_mem_pc4, ex_mem_store_data;
    logic [4:0]  ex_mem_register_number;
    logic [1:0]  ex_mem_register_source;
    logic        ex_mem_mem_read, ex_mem_mem_write, ex_mem_byte, ex_mem_unsigned;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        mem_stall, mem_fault;
    logic [31:0] mem_wb_alu_result, mem_wb_pc4, mem_wb_data;
    logic        mem_wb_alu_zero, mem_wb_write_register;
    logic [4:0]  mem_wb_register_number;
    logic [1:0]  mem_wb_register_source;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_alu, exp_pc4, exp_data;
    logic        exp_zero, exp_wr, exp_fault;
    logic [4:0]  exp_num;
    logic [1:0]  exp_src;

    mem_stage #(.TIMEOUT_CYCLES(T)) dut (
        .clock(clock), .reset(reset),
        .ex_mem_valid(ex_mem_valid), .ex_mem_alu_result(ex_mem_alu_result),
        .ex_mem_alu_zero(ex_mem_alu_zero), .ex_mem_write_register(ex_mem_write_register),
        .ex_mem_register_number(ex_mem_register_number), .ex_mem_register_source(ex_mem_register_source),
        .ex_mem_pc4(ex_mem_pc4), .ex_mem_store_data(ex_mem_store_data),
        .ex_mem_mem_read(ex_mem_mem_read), .ex_mem_mem_write(ex_mem_mem_write),
        .ex_mem_byte(ex_mem_byte), .ex_mem_unsigned(ex_mem_unsigned),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
        .dmem_rdata(dmem_rdata), .mem_stall(mem_stall), .mem_fault(mem_fault),
        .mem_wb_alu_result(mem_wb_alu_result), .mem_wb_alu_zero(mem_wb_alu_zero),
        .mem_wb_write_register(mem_wb_write_register), .mem_wb_register_number(mem_wb_register_number),
        .mem_wb_register_source(mem_wb_register_source), .mem_wb_pc4(mem_wb_pc4),
        .mem_wb_data(mem_wb_data)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_wb();
        check("wb_alu",   mem_wb_alu_result, exp_alu);
        check("wb_zero",  32'(mem_wb_alu_zero), 32'(exp_zero));
        check("wb_wr",    32'(mem_wb_write_register), 32'(exp_wr));
        check("wb_num",   32'(mem_wb_register_number), 32'(exp_num));
        check("wb_src",   32'(mem_wb_register_source), 32'(exp_src));
        check("wb_pc4",   mem_wb_pc4, exp_pc4);
        check("wb_data",  mem_wb_data, exp_data);
        check("wb_fault", 32'(mem_fault), 32'(exp_fault));
    endtask

    // One instruction held in EX/MEM until it leaves; lat = cycles before dmem_ready (>T never completes)
    task automatic run_instr(input logic v, input logic rd, input logic wr, input logic wreg,
                             input logic [4:0] rnum, input logic [1:0] src, input logic [31:0] alu,
                             input logic [31:0] st, input logic [31:0] rdat, input logic byt,
                             input logic uns, input int lat, output int stalls);
        logic        acc, tmo, done, flt, stall_e, req_e, rdy;
        logic [31:0] pc4, ld, wd_e;
        logic [3:0]  be_e;
        int          k, sh;
        pc4 = $urandom;
        acc = v & (rd | wr);
        tmo = acc && (lat > T);
        ld = rdat; be_e = 4'hF; wd_e = st;
`ifdef MEM_BYTE_ACCESS_EN
        if (byt) begin
            sh   = int'(alu[1:0]);
            be_e = 4'(1 << sh);
            wd_e = {24'h0, st[7:0]} * 32'h0101_0101;
            ld   = (rdat >> (8 * sh)) & 32'hFF;
            if (!uns && ld >= 32'd128) ld = ld | 32'hFFFF_FF00;
        end
`endif
        ex_mem_valid = v; ex_mem_mem_read = rd; ex_mem_mem_write = wr;
        ex_mem_write_register = wreg; ex_mem_register_number = rnum;
        ex_mem_register_source = src; ex_mem_alu_result = alu; ex_mem_alu_zero = (alu == 32'd0);
        ex_mem_pc4 = pc4; ex_mem_store_data = st; ex_mem_byte = byt; ex_mem_unsigned = uns;
        dmem_rdata = rdat;
        stalls = 0; k = 0; done = 1'b0; flt = 1'b0;
        while (!done) begin
            if (!acc) begin
                rdy = 1'($urandom_range(0, 1)); stall_e = 1'b0; req_e = 1'b0; done = 1'b1;
            end else if (tmo) begin
                rdy = 1'b0;
                stall_e = (k <= T); req_e = (k <= T);
                if (k > T) begin flt = 1'b1; done = 1'b1; end
            end else begin
                rdy = (k == lat); stall_e = (k < lat); req_e = 1'b1; done = (k == lat);
            end
            dmem_ready = rdy;
            #1;
            check("stall", 32'(mem_stall), 32'(stall_e));
            check("req", 32'(dmem_req), 32'(req_e));
            if (req_e) check("addr", dmem_addr, {alu[31:2], 2'b00});
            if (req_e && done) begin
                check("we", 32'(dmem_we), 32'(wr));
                if (wr) begin
                    check("be", 32'(dmem_be), 32'(be_e));
                    check("wdata", dmem_wdata, wd_e);
                end
            end
            @(posedge clock); #1;
            if (stall_e) begin
                exp_wr = 1'b0; exp_fault = 1'b0; stalls++;
            end else begin
                exp_alu = alu; exp_zero = (alu == 32'd0); exp_num = rnum; exp_src = src;
                exp_pc4 = pc4; exp_wr = v & wreg & ~flt; exp_fault = flt;
                exp_data = (!flt && v && rd && !wr) ? ld : 32'd0;
            end
            check_wb();
            k++;
        end
    endtask

    task automatic clear_model();
        exp_alu = 0; exp_pc4 = 0; exp_data = 0; exp_zero = 0; exp_wr = 0;
        exp_fault = 0; exp_num = 0; exp_src = 0;
    endtask

    initial begin
        int st, lat;
        logic [1:0] kind;
        reset = 1'b1;
        ex_mem_valid = 0; ex_mem_alu_result = 0; ex_mem_alu_zero = 0; ex_mem_write_register = 0;
        ex_mem_register_number = 0; ex_mem_register_source = 0; ex_mem_pc4 = 0; ex_mem_store_data = 0;
        ex_mem_mem_read = 0; ex_mem_mem_write = 0; ex_mem_byte = 0; ex_mem_unsigned = 0;
        dmem_ready = 0; dmem_rdata = 0;
        clear_model();
        #12;
        check_wb();
        check("rst_stall", 32'(mem_stall), 32'd0);
        check("rst_req", 32'(dmem_req), 32'd0);
        @(posedge clock); #1 reset = 1'b0;

        run_instr(1, 0, 0, 1, 5'd3, 2'd0, 32'h1234, 32'h0, $urandom, 0, 0, 0, st);
        check("alu_1234", mem_wb_alu_result, 32'h1234);
        check("alu_stalls", 32'(st), 32'd0);

        run_instr(1, 1, 0, 1, 5'd7, 2'd2, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, st);
        check("ld_data", mem_wb_data, 32'hDEAD_BEEF);
        check("ld_wr", 32'(mem_wb_write_register), 32'd1);
        check("ld_stalls", 32'(st), 32'd0);

        run_instr(1, 0, 1, 0, 5'd0, 2'd0, 32'h204, 32'hCAFE_F00D, $urandom, 0, 0, 3, st);
        check("st_stalls", 32'(st), 32'd3);

        run_instr(1, 1, 0, 1, 5'd9, 2'd2, 32'h308, 32'h0, $urandom, 0, 0, 1000, st);
        check("tmo_stalls", 32'(st), 32'(T + 1));
        check("tmo_fault", 32'(mem_fault), 32'd1);
        check("tmo_wr", 32'(mem_wb_write_register), 32'd0);
        run_instr(1, 0, 0, 1, 5'd4, 2'd1, 32'h5, 32'h0, $urandom, 0, 0, 0, st);
        check("fault_drop", 32'(mem_fault), 32'd0);

        // Reset arriving while the stage is waiting on memory
        ex_mem_valid = 1; ex_mem_mem_read = 0; ex_mem_mem_write = 1; dmem_ready = 0;
        ex_mem_write_register = 1; ex_mem_register_number = 5'd11; ex_mem_alu_result = 32'h40;
        repeat (2) @(posedge clock);
        #3 reset = 1'b1;
        #1;
        clear_model();
        check("rstw_req", 32'(dmem_req), 32'd0);
        check("rstw_stall", 32'(mem_stall), 32'd0);
        check_wb();
        ex_mem_valid = 0;
        @(posedge clock); #1 reset = 1'b0;
        run_instr(1, 0, 1, 0, 5'd0, 2'd0, 32'h44, 32'h1357_9BDF, $urandom, 0, 0, 2, st);
        check("post_rst_stalls", 32'(st), 32'd2);

`ifdef MEM_BYTE_ACCESS_EN
        run_instr(1, 1, 0, 1, 5'd12, 2'd2, 32'h1003, 32'h0, 32'h80FF_FF7F, 1, 0, 0, st);
        check("lb_sext", mem_wb_data, 32'hFFFF_FF80);
        run_instr(1, 1, 0, 1, 5'd12, 2'd2, 32'h1000, 32'h0, 32'h80FF_FF7F, 1, 1, 1, st);
        check("lbu_lane0", mem_wb_data, 32'h0000_007F);
`endif

        for (int i = 0; i < 300; i++) begin
            kind = 2'($urandom_range(0, 3));
            lat  = $urandom_range(0, 9);
            if (lat > 6) lat = 1000;
            run_instr(1'($urandom_range(0, 9) != 0), kind == 2'd1 || kind == 2'd3, kind[1],
                      1'($urandom), 5'($urandom), 2'($urandom), $urandom, $urandom, $urandom,
                      1'($urandom), 1'($urandom), lat, st);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
